// File: rtl/instr_mem_v3.sv
// Instruction memory with an integrated fetch engine. The program image is loaded
// through the store port and streamed out over a valid/ready handshake.
module instr_mem_v3 #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned RESET_PC = 0,
  parameter bit          WRAP     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              store_en,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              fetch_en,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic              fire;
  logic              at_end;

  always_comb begin
    fire   = fetch_en & ~store_en & ~redirect_en & ~halted & (~instr_valid | instr_ready);
    at_end = !WRAP && (pc == LAST_PC);
  end

  // Program image is deliberately not reset so it survives a reset.
  always_ff @(posedge clk) begin
    if (store_en) mem[store_addr] <= store_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= START_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else if (redirect_en) begin
      pc          <= redirect_addr;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (fire) begin
      instr       <= mem[pc];
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      if (at_end) halted <= 1'b1;
      else        pc     <= pc + ADDR_W'(1);
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_v3.sv
// Bench for instr_mem_v3: directed vector table, corner sequences and random
// traffic on a wrapping and a halting instance checked against a reference model.
module tb_instr_mem_v3;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, store_en, fetch_en, redirect_en, instr_ready;
  logic [AW-1:0] store_addr, redirect_addr;
  logic [DW-1:0] store_data;
  logic          w_valid, h_valid, w_halted, h_halted;
  logic [DW-1:0] w_instr, h_instr;
  logic [AW-1:0] w_pc, h_pc;

  instr_mem_v3 #(.DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(0), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .store_en(store_en), .store_addr(store_addr),
    .store_data(store_data), .fetch_en(fetch_en), .redirect_en(redirect_en),
    .redirect_addr(redirect_addr), .instr_ready(instr_ready),
    .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc), .halted(w_halted));

  instr_mem_v3 #(.DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(0), .WRAP(1'b0)) dut_h (
    .clk(clk), .reset(reset), .store_en(store_en), .store_addr(store_addr),
    .store_data(store_data), .fetch_en(fetch_en), .redirect_en(redirect_en),
    .redirect_addr(redirect_addr), .instr_ready(instr_ready),
    .instr_valid(h_valid), .instr(h_instr), .instr_pc(h_pc), .halted(h_halted));

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: fetch engine state expressed as plain integers
  typedef struct {
    int          pc;
    bit          valid;
    logic [31:0] word;
    int          wpc;
    bit          halted;
  } mstate_t;

  mstate_t     mw, mh;
  logic [31:0] mmem [DEPTH];

  function automatic mstate_t next_state(mstate_t s, bit wrap);
    mstate_t n = s;
    bool_fire: begin end
    if (reset) begin
      n.pc = 0; n.valid = 0; n.word = 0; n.wpc = 0; n.halted = 0;
    end else if (redirect_en) begin
      n.pc = int'(redirect_addr); n.valid = 0; n.halted = 0;
    end else if (fetch_en && !store_en && !s.halted && (!s.valid || instr_ready)) begin
      n.word  = mmem[s.pc];
      n.wpc   = s.pc;
      n.valid = 1;
      if (!wrap && s.pc == DEPTH - 1) n.halted = 1;
      else n.pc = (s.pc + 1) % DEPTH;
    end else if (s.valid && instr_ready) begin
      n.valid = 0;
    end
    return n;
  endfunction

  task automatic cmp_model();
    chk("w_valid", 64'(w_valid), 64'(mw.valid));
    chk("w_instr", 64'(w_instr), 64'(mw.word));
    chk("w_pc", 64'(w_pc), 64'(mw.wpc));
    chk("w_halted", 64'(w_halted), 64'(mw.halted));
    chk("h_valid", 64'(h_valid), 64'(mh.valid));
    chk("h_instr", 64'(h_instr), 64'(mh.word));
    chk("h_pc", 64'(h_pc), 64'(mh.wpc));
    chk("h_halted", 64'(h_halted), 64'(mh.halted));
  endtask

  task automatic step();
    @(posedge clk);
    mw = next_state(mw, 1'b1);
    mh = next_state(mh, 1'b0);
    if (store_en) mmem[store_addr] = store_data;
    #1;
    cmp_model();
  endtask

  task automatic idle_inputs();
    reset = 0; store_en = 0; store_addr = '0; store_data = '0;
    fetch_en = 0; redirect_en = 0; redirect_addr = '0; instr_ready = 0;
  endtask

  typedef struct {
    bit          f, r, se, re;
    logic [5:0]  sa, ra;
    logic [31:0] sd;
    bit          ev;
    logic [31:0] ei;
    logic [5:0]  ep;
    string       tag;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string tag, bit f, bit r, bit se, logic [5:0] sa, logic [31:0] sd,
                              bit re, logic [5:0] ra, bit ev, logic [31:0] ei, logic [5:0] ep);
    vec_t v;
    v.tag = tag; v.f = f; v.r = r; v.se = se; v.sa = sa; v.sd = sd;
    v.re = re; v.ra = ra; v.ev = ev; v.ei = ei; v.ep = ep;
    tbl.push_back(v);
  endfunction

  initial begin
    bit found;
    idle_inputs();
    reset = 1;
    step();
    reset = 0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      store_en = 1; store_addr = AW'(i); store_data = 32'h1000_0000 + i;
      step();
    end
    store_en = 0;

    reset = 1;
    step();
    chk("rst_valid", 64'(w_valid), 64'd0);
    chk("rst_instr", 64'(w_instr), 64'd0);
    chk("rst_pc", 64'(w_pc), 64'd0);
    chk("rst_halted", 64'(w_halted), 64'd0);
    reset = 0;

    for (int i = 0; i < 6; i++) add("stream", 1, 1, 0, 0, 0, 0, 0, 1, 32'h1000_0000 + i, 6'(i));
    for (int i = 0; i < 3; i++) add("stall", 1, 0, 0, 0, 0, 0, 0, 1, 32'h1000_0005, 6'd5);
    for (int i = 6; i <= 10; i++) add("resume", 1, 1, 0, 0, 0, 0, 0, 1, 32'h1000_0000 + i, 6'(i));
    add("redir_flush", 1, 0, 0, 0, 0, 1, 6'd40, 0, 32'h1000_000A, 6'd10);
    for (int i = 40; i <= 42; i++) add("redir_stream", 1, 1, 0, 0, 0, 0, 0, 1, 32'h1000_0000 + i, 6'(i));
    add("store_block", 1, 1, 1, 6'd7, 32'hDEAD_BEEF, 0, 0, 0, 32'h1000_002A, 6'd42);
    add("after_store", 1, 1, 0, 0, 0, 0, 0, 1, 32'h1000_002B, 6'd43);
    add("redir6", 1, 1, 0, 0, 0, 1, 6'd6, 0, 32'h1000_002B, 6'd43);
    add("fetch6", 1, 1, 0, 0, 0, 0, 0, 1, 32'h1000_0006, 6'd6);
    add("fetch7_new", 1, 1, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 6'd7);
    add("fetch8", 1, 1, 0, 0, 0, 0, 0, 1, 32'h1000_0008, 6'd8);
    add("fetch_off_hold", 0, 0, 0, 0, 0, 0, 0, 1, 32'h1000_0008, 6'd8);
    add("fetch_off_hold2", 0, 0, 0, 0, 0, 0, 0, 1, 32'h1000_0008, 6'd8);
    add("fetch_off_drain", 0, 1, 0, 0, 0, 0, 0, 0, 32'h1000_0008, 6'd8);

    foreach (tbl[k]) begin
      fetch_en = tbl[k].f; instr_ready = tbl[k].r;
      store_en = tbl[k].se; store_addr = tbl[k].sa; store_data = tbl[k].sd;
      redirect_en = tbl[k].re; redirect_addr = tbl[k].ra;
      step();
      chk({tbl[k].tag, "_valid"}, 64'(w_valid), 64'(tbl[k].ev));
      chk({tbl[k].tag, "_instr"}, 64'(w_instr), 64'(tbl[k].ei));
      chk({tbl[k].tag, "_pc"}, 64'(w_pc), 64'(tbl[k].ep));
      chk({tbl[k].tag, "_halted"}, 64'(w_halted), 64'd0);
    end
    idle_inputs();

    // Reset in the middle of a stream
    fetch_en = 1; instr_ready = 1; redirect_en = 1; redirect_addr = 6'd18;
    step();
    redirect_en = 0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (w_valid && w_pc == 6'd20) begin found = 1; break; end
      step();
    end
    chk("reach_pc20", 64'(found), 64'd1);
    reset = 1;
    step();
    chk("midrst_valid", 64'(w_valid), 64'd0);
    chk("midrst_instr", 64'(w_instr), 64'd0);
    reset = 0;
    step();
    chk("restart_pc", 64'(w_pc), 64'd0);
    chk("restart_instr", 64'(w_instr), 64'h1000_0000);
    step();
    chk("restart_pc1", 64'(w_pc), 64'd1);

    // Wrap vs halt at end of memory
    redirect_en = 1; redirect_addr = 6'd60;
    step();
    redirect_en = 0;
    for (int k = 0; k < 4; k++) step();
    chk("end_w_pc", 64'(w_pc), 64'd63);
    chk("end_h_pc", 64'(h_pc), 64'd63);
    chk("end_h_halted", 64'(h_halted), 64'd1);
    chk("end_h_valid", 64'(h_valid), 64'd1);
    chk("end_w_halted", 64'(w_halted), 64'd0);
    step();
    chk("wrap_pc0", 64'(w_pc), 64'd0);
    chk("wrap_instr0", 64'(w_instr), 64'h1000_0000);
    chk("halt_drop", 64'(h_valid), 64'd0);
    step();
    chk("halt_stays", 64'(h_halted), 64'd1);
    chk("halt_no_fetch", 64'(h_valid), 64'd0);
    redirect_en = 1; redirect_addr = 6'd3;
    step();
    redirect_en = 0;
    chk("unhalt", 64'(h_halted), 64'd0);
    step();
    chk("unhalt_pc3", 64'(h_pc), 64'd3);
    chk("unhalt_instr3", 64'(h_instr), 64'h1000_0003);
    chk("unhalt_valid", 64'(h_valid), 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 199) == 0);
      store_en      = !reset && ($urandom_range(0, 9) == 0);
      store_addr    = AW'($urandom_range(0, DEPTH - 1));
      store_data    = $urandom;
      redirect_en   = ($urandom_range(0, 24) == 0);
      redirect_addr = AW'($urandom_range(0, DEPTH - 1));
      fetch_en      = ($urandom_range(0, 9) < 9);
      instr_ready   = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_mem_v3.md
# instr_mem_v3

Parametrised instruction memory with an integrated fetch engine. It holds the program image in a register array, which is loaded through a store port. It streams instructions to the decode stage over a valid/ready handshake and tags each one with its word address. It also supports PC redirect for branches and jumps, and a configurable wrap or halt policy at the end of memory.

## Interface

Parameters:
- DATA_W, default 32: instruction word width in bits.
- DEPTH, default 64: number of words. Must be ≥ 2 and a power of two.
- ADDR_W, default $clog2(DEPTH): word-address width. Derived; do not override.
- RESET_PC, default 0: word address fetched first after reset.
- WRAP, default 1: end-of-memory policy.
  - 1: pc wraps from DEPTH-1 to 0.
  - 0: the engine halts after fetching word DEPTH-1.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- store_en, input, 1: write store_data to store_addr this cycle.
- store_addr, input, ADDR_W: write word address.
- store_data, input, DATA_W: write data.
- fetch_en, input, 1: allows the fetch engine to issue fetches.
- redirect_en, input, 1: load pc from redirect_addr and flush the output.
- redirect_addr, input, ADDR_W: new fetch word address.
- instr_ready, input, 1: consumer accepts instr this cycle.
- instr_valid, output, 1: instr and instr_pc hold a valid fetched word.
- instr, output, DATA_W: fetched instruction.
- instr_pc, output, ADDR_W: word address of instr.
- halted, output, 1: end of memory reached with WRAP=0.

## Operation

- State: pc (ADDR_W), output register {instr_valid, instr, instr_pc}, halted flag, memory array mem[DEPTH].
- mem is not reset. Its contents survive reset.
- Write: when store_en=1, mem[store_addr] <= store_data. This takes effect for any fetch issued in a later cycle.
- fire = fetch_en & !store_en & !redirect_en & !halted & (!instr_valid | instr_ready).
- On fire:
  - instr <= mem[pc], instr_pc <= pc, instr_valid <= 1.
  - pc <= pc+1, computed modulo DEPTH.
  - If WRAP=0 and pc == DEPTH-1, then halted <= 1 and pc is held at DEPTH-1.
- No fire, instr_valid=1, instr_ready=1: instr_valid <= 0. instr and instr_pc keep their values, which are don't-care.
- No fire, instr_valid=1, instr_ready=0: instr, instr_pc and instr_valid all hold.
- Redirect (redirect_en=1): pc <= redirect_addr, instr_valid <= 0 (flush, even if the consumer is not ready), halted <= 0. No fetch is issued that cycle.
- Priority: reset > redirect > store blocks fetch > fire.
- store_en and redirect_en in the same cycle: both take effect.
- Store during a stalled output: the output register is unaffected, even if store_addr == instr_pc. The already-fetched word is not updated.
- Store while stalled with ready: instr_valid drops as in the no-fire case.
- fetch_en deassertion stops new fires only. A pending valid word stays presented until it is accepted.
- Arithmetic: pc increments in ADDR_W bits with natural wrap. All addresses are word addresses.

## Timing

- Reset values (one cycle of reset=1 is sufficient): pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0.
- Fetch latency: fire in cycle N makes instr_valid=1 with data in cycle N+1.
- Throughput: one word per cycle while fetch_en=1, instr_ready=1 and there is no store or redirect.
- Handshake:
  - A transfer occurs on a cycle with instr_valid & instr_ready.
  - While instr_valid=1 and instr_ready=0, instr and instr_pc are stable.
  - instr_valid never drops without a transfer, except on redirect or reset.
- Redirect to first valid: redirect in cycle N makes instr_valid=0 in N+1. The first fire is in N+1, and instr_pc=redirect_addr is valid in N+2.
- Store to readable: a word stored in cycle N may be fetched by a fire in N+1 or later.
- Halt: halted rises in the cycle after the fire of word DEPTH-1, together with that word's instr_valid.
- Reset mid-stream: the output is dropped immediately. The next fetch is from RESET_PC. Memory contents are kept.

## Test plan

- Load and stream:
  - Stimulus: store mem[i]=0x1000_0000+i for i=0..63. Reset. fetch_en=1, ready=1.
  - Required: instr_valid first at cycle 2 after reset release, then 0x10000000, 0x10000001, … back-to-back with instr_pc 0,1,2…
- Backpressure:
  - Stimulus: drop ready for 3 cycles while instr_pc=5 is valid.
  - Required: instr=0x10000005 and instr_pc=5 are held stable. After ready returns, 6 follows with no loss or duplication.
- Redirect:
  - Stimulus: redirect_addr=40 while the word at pc 10 is valid and ready=0.
  - Required: instr_valid=0 the next cycle, then instr_pc 40, 41… Word 10 is never transferred.
- Wrap and halt:
  - Stimulus: WRAP=1.
  - Required: word 63 is followed by word 0.
  - Stimulus: WRAP=0.
  - Required: after 63, halted=1 and instr_valid drops once 63 is accepted. Redirect to 3 clears halted and streams from 3.
- Store collision:
  - Stimulus: store_en=1 to addr 7 = 0xDEADBEEF while streaming with ready=1.
  - Required: no fire in that cycle. The stream resumes at the next pc. A later fetch of 7 returns 0xDEADBEEF.
- Reset mid-stream:
  - Stimulus: reset for 1 cycle while instr_pc=20 is valid.
  - Required: instr_valid=0 and instr=0. The stream restarts at RESET_PC with the previously loaded data intact.
